// File: rtl/pulse_capture.sv
// pulse_capture: serial-to-parallel receiver for the pulse_generator stream.
// Captures WIDTH bits MSB-first and reports popcount and circular edge count.
module pulse_capture #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             capture_flag,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word_out,
  output logic [CW-1:0]    ones_count,
  output logic [CW-1:0]    edge_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    CAPT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    ones_acc;
  logic [CW-1:0]    edge_acc;
  logic             first_bit;

  logic             start;
  logic             sample;
  logic             last;
  logic             diff_prev;
  logic             diff_wrap;
  logic [WIDTH-1:0] word_nxt;
  logic [CW-1:0]    ones_nxt;
  logic [CW-1:0]    edge_nxt;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and per-edge control strobes
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    sample    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture_flag) begin
          state_nxt = CAPT;
          start     = 1'b1;
        end
      end
      CAPT: begin
        sample = 1'b1;
        if (idx == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator updates for the bit sampled on this edge
  always_comb begin
    diff_prev = (idx != '0) && (serial_in != shift_reg[0]);
    diff_wrap = (serial_in != first_bit);
    word_nxt  = {shift_reg[WIDTH-2:0], serial_in};
    ones_nxt  = ones_acc + CW'(serial_in);
    edge_nxt  = edge_acc + CW'(diff_prev);
  end

  // Datapath: shifting, running counts and result publication
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg  <= '0;
      idx        <= '0;
      ones_acc   <= '0;
      edge_acc   <= '0;
      first_bit  <= 1'b0;
      word_out   <= '0;
      ones_count <= '0;
      edge_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        idx      <= '0;
        ones_acc <= '0;
        edge_acc <= '0;
      end
      if (sample) begin
        shift_reg <= word_nxt;
        ones_acc  <= ones_nxt;
        edge_acc  <= edge_nxt;
        idx       <= idx + 1'b1;
        if (idx == '0) first_bit <= serial_in;
        if (last) begin
          word_out   <= word_nxt;
          ones_count <= ones_nxt;
          edge_count <= edge_nxt + CW'(diff_wrap);
          busy       <= 1'b0;
          done       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture: randomized and directed checks of pulse_capture
// against a word-level reference model.
module tb_pulse_capture;

  localparam int W  = 16;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          capture_flag = 1'b0;
  logic          serial_in = 1'b0;
  logic [W-1:0]  word_out;
  logic [CW-1:0] ones_count;
  logic [CW-1:0] edge_count;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  pulse_capture #(.WIDTH(W), .CW(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .capture_flag(capture_flag),
    .serial_in   (serial_in),
    .word_out    (word_out),
    .ones_count  (ones_count),
    .edge_count  (edge_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int popcount(input logic [W-1:0] w);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(w[i]);
    return n;
  endfunction

  function automatic int circ_edges(input logic [W-1:0] w);
    int n = 0;
    for (int i = 0; i < W; i++)
      if (w[i] != w[(i + 1) % W]) n++;
    return n;
  endfunction

  task automatic drive_capture(
    input  logic [W-1:0]  pat,
    input  int            repulse,
    output logic [W-1:0]  w,
    output logic [CW-1:0] o,
    output logic [CW-1:0] ed,
    output int            done_at,
    output int            n_done,
    output int            busy_bad,
    output int            changed
  );
    logic [W-1:0] w0;
    w0 = word_out;
    done_at = 0;
    n_done = 0;
    busy_bad = 0;
    changed = 0;
    for (int e = 1; e <= W + 1; e++) begin
      serial_in = (e >= 2) ? pat[W + 1 - e] : 1'($urandom);
      capture_flag = (e == 1) || (e == repulse);
      step();
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = e;
      end
      if (e <= W && !busy) busy_bad++;
      if (e == W + 1 && busy) busy_bad++;
      if (e <= W && word_out !== w0) changed++;
    end
    capture_flag = 1'b0;
    w = word_out;
    o = ones_count;
    ed = edge_count;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    capture_flag = 1'b1;
    step();
    step();
    tests++;
    if (word_out !== '0) begin
      fails++;
      $display("FAIL reset_word got %h want 0", word_out);
    end
    tests++;
    if ({ones_count, edge_count} !== '0) begin
      fails++;
      $display("FAIL reset_counts got %0d/%0d want 0/0",
               ones_count, edge_count);
    end
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags got busy=%b done=%b want 0 0",
               busy, done);
    end
    reset = 1'b0;
    capture_flag = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_wins_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_patterns();
    logic [W-1:0] pats [8] = '{16'hAAAA, 16'hCCCC, 16'hF0F0, 16'h0101,
                               16'hE000, 16'hFFE0, 16'h0000, 16'hFFFF};
    int eones [8] = '{8, 8, 8, 2, 3, 11, 0, 16};
    int eedg  [8] = '{16, 8, 4, 4, 2, 2, 0, 0};
    logic [W-1:0]  pat, w;
    logic [CW-1:0] o, ed;
    int da, nd, bb, ch, xo, xe;
    for (int n = 0; n < 20; n++) begin
      if (n < 8) begin
        pat = pats[n];
        xo = eones[n];
        xe = eedg[n];
      end else begin
        pat = 16'($urandom);
        xo = popcount(pat);
        xe = circ_edges(pat);
      end
      drive_capture(pat, 0, w, o, ed, da, nd, bb, ch);
      tests++;
      if (w !== pat) begin
        fails++;
        $display("FAIL pat_word got %h want %h", w, pat);
      end
      tests++;
      if (int'(o) != xo || int'(ed) != xe) begin
        fails++;
        $display("FAIL pat_counts %h got %0d/%0d want %0d/%0d",
                 pat, o, ed, xo, xe);
      end
      tests++;
      if (da != W + 1 || nd != 1) begin
        fails++;
        $display("FAIL pat_done_edge got %0d (n=%0d) want %0d",
                 da, nd, W + 1);
      end
      tests++;
      if (bb != 0 || ch != 0) begin
        fails++;
        $display("FAIL pat_busy_hold got bad=%0d chg=%0d want 0 0",
                 bb, ch);
      end
      step();
      tests++;
      if (done !== 1'b0 || word_out !== pat) begin
        fails++;
        $display("FAIL pat_done_width got done=%b word=%h want 0 %h",
                 done, word_out, pat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       bits [64];
    logic       exp_done [64];
    logic [W-1:0] exp_w;
    int req, bad_done, bad_busy;
    for (int e = 0; e < 64; e++) exp_done[e] = 1'b0;
    req = 1;
    while (req + W <= 40) begin
      exp_done[req + W] = 1'b1;
      req = req + W + 1;
    end
    bad_done = 0;
    bad_busy = 0;
    for (int e = 1; e <= 40; e++) begin
      capture_flag = 1'b1;
      serial_in = 1'($urandom);
      bits[e] = serial_in;
      step();
      if (done !== exp_done[e]) bad_done++;
      if (busy !== !exp_done[e]) bad_busy++;
      if (e == W + 1 || e == 2 * W + 2) begin
        for (int i = 0; i < W; i++)
          exp_w[W - 1 - i] = bits[e - W + 1 + i];
        tests++;
        if (word_out !== exp_w || int'(ones_count) != popcount(exp_w) ||
            int'(edge_count) != circ_edges(exp_w)) begin
          fails++;
          $display("FAIL b2b_word@%0d got %h %0d/%0d want %h %0d/%0d",
                   e, word_out, ones_count, edge_count, exp_w,
                   popcount(exp_w), circ_edges(exp_w));
        end
      end
    end
    capture_flag = 1'b0;
    tests++;
    if (bad_done != 0) begin
      fails++;
      $display("FAIL b2b_done got %0d bad edges want 0", bad_done);
    end
    tests++;
    if (bad_busy != 0) begin
      fails++;
      $display("FAIL b2b_busy got %0d bad edges want 0", bad_busy);
    end
    for (int e = 0; e < W + 2; e++) step();
  endtask

  task automatic test_ignored();
    logic [W-1:0]  pat, w;
    logic [CW-1:0] o, ed;
    int da, nd, bb, ch;
    for (int n = 0; n < 3; n++) begin
      pat = 16'($urandom);
      drive_capture(pat, 5, w, o, ed, da, nd, bb, ch);
      tests++;
      if (w !== pat || da != W + 1 || nd != 1) begin
        fails++;
        $display("FAIL ignored_req got %h @%0d want %h @%0d",
                 w, da, pat, W + 1);
      end
      step();
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL ignored_restart got busy=%b want 0", busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0]  pat, w;
    logic [CW-1:0] o, ed;
    int da, nd, bb, ch, nd2;
    drive_capture(16'h1234, 0, w, o, ed, da, nd, bb, ch);
    step();
    nd2 = 0;
    for (int e = 1; e <= 20; e++) begin
      capture_flag = (e == 1);
      reset = (e == 8);
      serial_in = 1'($urandom);
      step();
      if (done) nd2++;
      if (e == 8) begin
        tests++;
        if ({word_out, ones_count, edge_count, busy, done} !== '0) begin
          fails++;
          $display("FAIL mid_reset_out got %h %0d %0d %b %b want 0",
                   word_out, ones_count, edge_count, busy, done);
        end
      end
    end
    reset = 1'b0;
    capture_flag = 1'b0;
    tests++;
    if (nd2 != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_nodone got n=%0d busy=%b want 0 0",
               nd2, busy);
    end
    pat = 16'($urandom);
    drive_capture(pat, 0, w, o, ed, da, nd, bb, ch);
    tests++;
    if (w !== pat || da != W + 1 || int'(o) != popcount(pat) ||
        int'(ed) != circ_edges(pat)) begin
      fails++;
      $display("FAIL mid_reset_fresh got %h @%0d %0d/%0d want %h @%0d",
               w, da, o, ed, pat, W + 1);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
